// File: rtl/sd_sector_reader.sv
// Multi-sector read sequencer for the SPI-mode SD controller: issues one read per
// sector, captures the strobed bytes and streams them out through a FWFT byte FIFO.
module sd_sector_reader #(
  parameter int FIFO_DEPTH   = 16,
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_SHIFT   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [22:0] base_sector,
  input  logic [15:0] num_sectors,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_addr,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] sectors_left
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SECTOR_BYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(SECTOR_BYTES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_ISSUE      = 3'd2,
    S_STREAM     = 3'd3,
    S_NEXT       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [22:0]   ptr_q, ptr_d;
  logic [15:0]   left_q, left_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [31:0]   addr_q, addr_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          strobe_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   level_q;

  logic          edge_s, push_s, pop_s, full_s, push_ok_s;
  logic [31:0]   ptr_ext_s;

  assign edge_s    = sd_byte_available & ~strobe_q;
  assign push_s    = (state_q == S_STREAM) && edge_s;
  assign pop_s     = (level_q != '0) && out_ready;
  assign full_s    = (level_q == LVL_FULL);
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign ptr_ext_s = {9'd0, ptr_q};

  // Next-state and bookkeeping decode
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (num_sectors == 16'd0) begin
            done_d = 1'b1;
          end else begin
            ptr_d   = base_sector;
            left_d  = num_sectors;
            state_d = S_WAIT_READY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_READY: begin
        if (sd_ready) begin
          addr_d  = ptr_ext_s << ADDR_SHIFT;
          rd_d    = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT_READY;
        end
      end
      S_ISSUE: begin
        if (!sd_ready) begin
          rd_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_STREAM: begin
        // dropped bytes still count toward the sector length
        if (edge_s && (cnt_q == LAST_BYTE)) begin
          left_d  = left_q - 16'd1;
          ptr_d   = ptr_q + 23'd1;
          state_d = S_NEXT;
        end else if (edge_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_NEXT: begin
        if (left_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers and strobe history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 23'd0;
      left_q   <= 16'd0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      addr_q   <= 32'd0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      left_q   <= left_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      strobe_q <= sd_byte_available;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok_s) wp_q <= wp_q + PTR_ONE;
      if (pop_s)     rp_q <= rp_q + PTR_ONE;
      case ({push_ok_s, pop_s})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wp_q] <= sd_dout;
  end

  assign sd_rd        = rd_q;
  assign sd_addr      = addr_q;
  assign out_data     = mem_q[rp_q];
  assign out_valid    = (level_q != '0);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign sectors_left = left_q;
endmodule

// File: tb/tb_sd_sector_reader.sv
// Randomized bench for sd_sector_reader: a behavioural SD controller drives the
// read handshake and byte strobes; a queue model predicts the output byte stream.
module tb_sd_sector_reader;
  localparam int DEPTH  = 16;
  localparam int SECTOR = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [22:0] base_sector = 23'd0;
  logic [15:0] num_sectors = 16'd0;
  logic        sd_ready = 1'b0;
  logic        sd_byte_available = 1'b0;
  logic [7:0]  sd_dout = 8'd0;
  logic        sd_rd;
  logic [31:0] sd_addr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done, overflow;
  logic [15:0] sectors_left;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_rises = 0;
  int rdy_mode = 0;   // 0: never accept, 1: always accept, 2: random accept
  logic rd_prev = 1'b0;
  logic prev_av = 1'b0;
  logic exp_ovf = 1'b0;
  logic [7:0] exp_q[$];

  sd_sector_reader #(.FIFO_DEPTH(DEPTH), .SECTOR_BYTES(SECTOR), .ADDR_SHIFT(9)) dut (
    .clk(clk), .reset(reset), .start(start), .base_sector(base_sector),
    .num_sectors(num_sectors), .sd_ready(sd_ready),
    .sd_byte_available(sd_byte_available), .sd_dout(sd_dout), .sd_rd(sd_rd),
    .sd_addr(sd_addr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow),
    .sectors_left(sectors_left)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Consumer and FIFO model: decide out_ready, check the head, model captures.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      check_eq("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check_eq("out_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (sd_byte_available && !prev_av) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(sd_dout);
        else exp_ovf = 1'b1;
      end
    end
    prev_av = sd_byte_available;
  end

  // Event monitors for done pulses and read requests.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check_eq("done_busy", busy, 1'b0);
    end
    if (sd_rd && !rd_prev) rd_rises++;
    rd_prev = sd_rd;
  end

  function automatic logic [31:0] sector_addr(input logic [22:0] p);
    logic [31:0] a;
    a = 32'(p) * 32'd512;
    return a;
  endfunction

  // One controller read: handshake, then SECTOR strobes (or stop early at stop_at).
  task automatic serve_sector(input logic [31:0] exp_addr, input int hold,
                              input int stop_at, input bit pulse);
    int t;
    sd_ready = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      check_eq("rd_early", sd_rd, 1'b0);
    end
    sd_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!sd_rd && t < 20);
    check_eq("rd_latency", t, 1);
    check_eq("rd_addr", sd_addr, exp_addr);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check_eq("rd_hold", {sd_rd, sd_addr}, {1'b1, exp_addr});
    end
    sd_ready = 1'b0;
    @(negedge clk);
    check_eq("rd_drop", sd_rd, 1'b0);
    for (int i = 0; i < SECTOR; i++) begin
      if (i == stop_at) return;
      sd_dout = (rdy_mode == 1) ? 8'(i) : 8'($urandom);
      sd_byte_available = 1'b1;
      if (pulse && i == 200) begin
        start = 1'b1;
        base_sector = 23'($urandom);
        num_sectors = 16'd7;
      end
      repeat (hold) @(negedge clk);
      start = 1'b0;
      sd_byte_available = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    rdy_mode = 1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_timeout", t < 200, 1'b1);
  endtask

  task automatic run_xfer(input logic [22:0] base, input logic [15:0] num,
                          input int hold, input int mode, input bit pulse);
    int d0;
    int t;
    d0 = done_cnt;
    rdy_mode = mode;
    @(negedge clk);
    start = 1'b1;
    base_sector = base;
    num_sectors = num;
    exp_ovf = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_start", busy, 1'b1);
    for (int s = 0; s < int'(num); s++) begin
      check_eq("left_pre", sectors_left, 64'(int'(num) - s));
      serve_sector(sector_addr(base + 23'(s)), hold, -1, pulse && s == 0);
      check_eq("left_post", sectors_left, 64'(int'(num) - s - 1));
      check_eq("overflow", overflow, exp_ovf);
    end
    t = 0;
    while (done_cnt == d0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_eq("done_once", done_cnt - d0, 1);
    check_eq("busy_end", busy, 1'b0);
    drain();
  endtask

  initial begin
    int r0;
    int d0;
    repeat (3) @(negedge clk);
    check_eq("rst_rd", sd_rd, 1'b0);
    check_eq("rst_addr", sd_addr, 32'd0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_left", sectors_left, 16'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    reset = 1'b0;

    // single sector, bytes 0x00..0xFF twice
    r0 = rd_rises;
    run_xfer(23'd5, 16'd1, 1, 1, 1'b0);
    check_eq("single_rd", rd_rises - r0, 1);
    check_eq("single_ovf", overflow, 1'b0);

    // pointer wrap with an ignored start mid-stream
    r0 = rd_rises;
    run_xfer(23'h7FFFFF, 16'd2, 1, 2, 1'b1);
    check_eq("wrap_rd", rd_rises - r0, 2);

    // full backpressure: first DEPTH bytes retained, rest dropped
    run_xfer(23'd77, 16'd1, 1, 0, 1'b0);
    check_eq("bp_ovf", overflow, 1'b1);

    // long strobes, one capture each
    run_xfer(23'($urandom), 16'd1, 3, 2, 1'b0);

    // zero-length transfer
    r0 = rd_rises;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    num_sectors = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_done", done, 1'b1);
    check_eq("zero_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("zero_rd", rd_rises - r0, 0);
    check_eq("zero_done_cnt", done_cnt - d0, 1);

    // reset at byte 100 of the first sector
    rdy_mode = 2;
    @(negedge clk);
    start = 1'b1;
    base_sector = 23'd1234;
    num_sectors = 16'd2;
    @(negedge clk);
    start = 1'b0;
    serve_sector(sector_addr(23'd1234), 1, 100, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_rd", sd_rd, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_left", sectors_left, 16'd0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_addr", sd_addr, 32'd0);
    run_xfer(23'($urandom), 16'd2, $urandom_range(1, 2), 2, 1'b0);
    check_eq("final_ovf", overflow, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
